// File: rtl/rhs_stim_sequencer.sv
`default_nettype none
// rhs_stim_sequencer: biphasic pulse-train sequencer that issues cathodic, anodic
// and off phase commands to an RHS command engine with tick-based phase timing.
// Revision: 1.0 - initial release
module rhs_stim_sequencer #(
  parameter int unsigned TICK_DIV = 2800
) (
  input  logic        rhs_aclk,
  input  logic        rhs_aresetn,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  cfg_chan_pos,
  input  logic [4:0]  cfg_chan_neg,
  input  logic        cfg_mono,
  input  logic [15:0] cfg_pulse_width,
  input  logic [15:0] cfg_ipd,
  input  logic [7:0]  cfg_num_pulse,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_phase,
  output logic [4:0]  cmd_chan_pos,
  output logic [4:0]  cmd_chan_neg,
  output logic        cmd_mono,
  output logic        busy,
  output logic [7:0]  pulse_idx,
  output logic        done,
  output logic        aborted
);

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] TICK = CNT_W'(TICK_DIV);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_CMD_CATH = 4'd2;
  localparam logic [3:0] S_CATH     = 4'd3;
  localparam logic [3:0] S_CMD_ANOD = 4'd4;
  localparam logic [3:0] S_ANOD     = 4'd5;
  localparam logic [3:0] S_CMD_OFF  = 4'd6;
  localparam logic [3:0] S_GAP      = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;

  localparam logic [1:0] PH_OFF  = 2'b00;
  localparam logic [1:0] PH_CATH = 2'b01;
  localparam logic [1:0] PH_ANOD = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pos_q, pos_d;
  logic [4:0]       neg_q, neg_d;
  logic             mono_q, mono_d;
  logic [15:0]      pw_q, pw_d;
  logic [15:0]      ipd_q, ipd_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       idx_q, idx_d;
  logic             abort_q, abort_d;

  logic [15:0]      pw_eff;
  logic [CNT_W-1:0] phase_len;
  logic [CNT_W-1:0] gap_len;
  logic             cnt_zero;

  // Counters are loaded with length-1 so a phase lasts exactly its length.
  assign pw_eff    = (pw_q == 16'd0) ? 16'd1 : pw_q;
  assign phase_len = ({16'd0, pw_eff} * TICK) - 32'd1;
  assign gap_len   = ({16'd0, ipd_q} * TICK) - 32'd1;
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    mono_d  = mono_q;
    pw_d    = pw_q;
    ipd_d   = ipd_q;
    num_d   = num_q;
    idx_d   = idx_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          abort_d = 1'b0;
        end
      end
      S_LOAD: begin
        pos_d   = cfg_chan_pos;
        neg_d   = cfg_chan_neg;
        mono_d  = cfg_mono;
        pw_d    = cfg_pulse_width;
        ipd_d   = cfg_ipd;
        num_d   = cfg_num_pulse;
        idx_d   = 8'd0;
        abort_d = abort;
        state_d = abort ? S_CMD_OFF : S_CMD_CATH;
      end
      S_CMD_CATH: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_CMD_OFF;
        end else if (cmd_ready) begin
          state_d = S_CATH;
        end
      end
      S_CATH: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_CMD_OFF;
        end else if (cnt_zero) begin
          state_d = S_CMD_ANOD;
        end
      end
      S_CMD_ANOD: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_CMD_OFF;
        end else if (cmd_ready) begin
          state_d = S_ANOD;
        end
      end
      S_ANOD: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_CMD_OFF;
        end else if (cnt_zero) begin
          state_d = S_CMD_OFF;
        end
      end
      S_CMD_OFF: begin
        if (cmd_ready) begin
          if (abort_q || abort) begin
            abort_d = 1'b1;
            state_d = S_FIN;
          end else if (idx_q == num_q) begin
            state_d = S_FIN;
          end else if (ipd_q == 16'd0) begin
            idx_d   = idx_q + 8'd1;
            state_d = S_CMD_CATH;
          end else begin
            state_d = S_GAP;
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_CMD_OFF;
        end else if (cnt_zero) begin
          idx_d   = idx_q + 8'd1;
          state_d = S_CMD_CATH;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reload on every state change; timed states count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      if (state_d == S_CATH || state_d == S_ANOD) begin
        cnt_d = phase_len;
      end else if (state_d == S_GAP) begin
        cnt_d = gap_len;
      end else begin
        cnt_d = '0;
      end
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge rhs_aclk or negedge rhs_aresetn) begin
    if (!rhs_aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      mono_q  <= 1'b0;
      pw_q    <= '0;
      ipd_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      mono_q  <= mono_d;
      pw_q    <= pw_d;
      ipd_q   <= ipd_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    cmd_phase = PH_OFF;
    if (state_q == S_CMD_CATH) begin
      cmd_phase = PH_CATH;
    end else if (state_q == S_CMD_ANOD) begin
      cmd_phase = PH_ANOD;
    end
  end

  assign cmd_valid    = (state_q == S_CMD_CATH) || (state_q == S_CMD_ANOD) ||
                        (state_q == S_CMD_OFF);
  assign cmd_chan_pos = pos_q;
  assign cmd_chan_neg = neg_q;
  assign cmd_mono     = mono_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);
  assign pulse_idx    = idx_q;
  assign done         = (state_q == S_FIN);
  assign aborted      = (state_q == S_FIN) && abort_q;

endmodule
`default_nettype wire

// File: tb/tb_rhs_stim_sequencer.sv
`default_nettype none
// tb_rhs_stim_sequencer: randomized and directed trains checked against a
// command-list model derived from the pulse-train timing rules.
module tb_rhs_stim_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  cfg_chan_pos = '0;
  logic [4:0]  cfg_chan_neg = '0;
  logic        cfg_mono = 1'b0;
  logic [15:0] cfg_pulse_width = '0;
  logic [15:0] cfg_ipd = '0;
  logic [7:0]  cfg_num_pulse = '0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_phase;
  logic [4:0]  cmd_chan_pos;
  logic [4:0]  cmd_chan_neg;
  logic        cmd_mono;
  logic        busy;
  logic [7:0]  pulse_idx;
  logic        done;
  logic        aborted;

  rhs_stim_sequencer #(.TICK_DIV(TD)) dut (
    .rhs_aclk        (clk),
    .rhs_aresetn     (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_chan_pos    (cfg_chan_pos),
    .cfg_chan_neg    (cfg_chan_neg),
    .cfg_mono        (cfg_mono),
    .cfg_pulse_width (cfg_pulse_width),
    .cfg_ipd         (cfg_ipd),
    .cfg_num_pulse   (cfg_num_pulse),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_phase       (cmd_phase),
    .cmd_chan_pos    (cmd_chan_pos),
    .cmd_chan_neg    (cmd_chan_neg),
    .cmd_mono        (cmd_mono),
    .busy            (busy),
    .pulse_idx       (pulse_idx),
    .done            (done),
    .aborted         (aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] ph;
    logic [4:0] cp;
    logic [4:0] cn;
    logic       mo;
    logic [7:0] idx;
    int         rise;
    int         acc;
    int         hold;
  } cmd_t;

  cmd_t cmds[$];
  int   done_cyc[$];
  bit   done_ab[$];
  int   start_cyc = 0;

  // Load-time configuration the model works from.
  logic [4:0]  e_pos, e_neg;
  logic        e_mono;
  logic [15:0] e_pw, e_ipd;
  logic [7:0]  e_num;
  int          rdy_mode = 0;

  // Handshake observer: logs accepted commands and train ends.
  bit          pend = 0;
  bit          abort_prev = 0;
  int          rise_c = 0;
  int          hold_c = 0;
  logic [12:0] held_pl = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      abort_prev = 0;
    end else begin
      if (start && !busy && !done) start_cyc = cyc;
      if (cmd_valid) begin
        if (!pend) begin
          rise_c = cyc;
          hold_c = 0;
        end else if (!abort_prev) begin
          check("payload_stable", {19'd0, cmd_phase, cmd_chan_pos, cmd_chan_neg, cmd_mono},
                {19'd0, held_pl});
        end
        hold_c++;
        check("phase_legal", {31'd0, cmd_phase == 2'b11}, 32'd0);
        if (cmd_ready) begin
          cmds.push_back('{cmd_phase, cmd_chan_pos, cmd_chan_neg, cmd_mono, pulse_idx,
                           rise_c, cyc, hold_c});
          pend = 0;
        end else begin
          pend = 1;
          held_pl = {cmd_phase, cmd_chan_pos, cmd_chan_neg, cmd_mono};
        end
      end else begin
        pend = 0;
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_ab.push_back(aborted);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      abort_prev = abort;
    end
  end

  // Command-engine ready: always, random, or after five waiting cycles.
  initial begin
    int w;
    w = 0;
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !cmd_valid) w = 0;
      case (rdy_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = 1'($urandom_range(0, 1));
        default: cmd_ready = cmd_valid && (w >= 5);
      endcase
      if (cmd_valid) w = cmd_ready ? 0 : w + 1;
    end
  end

  task automatic set_cfg(input logic [4:0] p, input logic [4:0] n, input logic m,
                         input logic [15:0] pw, input logic [15:0] ipd, input logic [7:0] num);
    e_pos = p; e_neg = n; e_mono = m; e_pw = pw; e_ipd = ipd; e_num = num;
    cfg_chan_pos = p; cfg_chan_neg = n; cfg_mono = m;
    cfg_pulse_width = pw; cfg_ipd = ipd; cfg_num_pulse = num;
  endtask

  task automatic clear_logs();
    cmds.delete();
    done_cyc.delete();
    done_ab.delete();
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        cfg_chan_pos    = 5'($urandom);
        cfg_chan_neg    = 5'($urandom);
        cfg_mono        = 1'($urandom);
        cfg_pulse_width = 16'($urandom_range(0, 3));
        cfg_ipd         = 16'($urandom_range(0, 3));
        cfg_num_pulse   = 8'($urandom_range(0, 5));
        start           = busy && ($urandom_range(0, 3) == 0);
      end
      if (done_cyc.size() > 0) break;
    end
    start = 1'b0;
    if (i >= budget) check("train_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Model: the train is (01,10,00) x (num+1); each phase runs max(pw,1) ticks
  // after its handshake, the gap runs ipd ticks, done follows the last off.
  task automatic verify(input int hold_exp);
    int n, len_ph, len_gap, k, d_exp;
    logic [1:0] ph_exp;
    n       = 3 * (int'(e_num) + 1);
    len_ph  = ((e_pw == 0) ? 1 : int'(e_pw)) * TD;
    len_gap = int'(e_ipd) * TD;
    check("cmd_count", cmds.size(), n);
    check("done_count", done_cyc.size(), 1);
    for (k = 0; k < n && k < cmds.size(); k++) begin
      ph_exp = (k % 3 == 0) ? 2'b01 : (k % 3 == 1) ? 2'b10 : 2'b00;
      check("cmd_phase", cmds[k].ph, ph_exp);
      check("cmd_chans", {cmds[k].cp, cmds[k].cn, cmds[k].mo}, {e_pos, e_neg, e_mono});
      check("pulse_idx", cmds[k].idx, k / 3);
      if (k == 0) d_exp = 2;
      else d_exp = ((k % 3) == 0) ? len_gap + 1 : len_ph + 1;
      check("cmd_spacing", (k == 0) ? cmds[k].rise - start_cyc : cmds[k].rise - cmds[k-1].acc,
            d_exp);
      if (hold_exp > 0) check("valid_hold", cmds[k].hold, hold_exp);
    end
    if (done_cyc.size() > 0 && cmds.size() > 0) begin
      check("done_latency", done_cyc[0] - cmds[cmds.size()-1].acc, 1);
      check("aborted_flag", {31'd0, done_ab[0]}, 32'd0);
    end
  endtask

  task automatic wait_cmds(input int cnt);
    int i;
    for (i = 0; i < 2000 && cmds.size() < cnt; i++) begin
      @(posedge clk);
      #1;
    end
    if (i >= 2000) check("cmd_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {7'd0, cmd_valid, cmd_phase, cmd_chan_pos, cmd_chan_neg, cmd_mono, busy,
                pulse_idx, done, aborted}, 32'd0);
  endtask

  initial begin
    int mode;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("idle_after_reset");

    // Basic bipolar train, ready always high.
    rdy_mode = 0;
    set_cfg(5'd17, 5'd18, 1'b0, 16'd1, 16'd2, 8'd1);
    clear_logs(); do_start(); wait_done(1'b0, 2000); verify(1);

    // Same train with a slow command engine.
    rdy_mode = 2;
    set_cfg(5'd17, 5'd18, 1'b0, 16'd1, 16'd2, 8'd1);
    clear_logs(); do_start(); wait_done(1'b0, 2000); verify(6);

    // Zero width, zero gap, single pulse.
    rdy_mode = 0;
    set_cfg(5'd3, 5'd9, 1'b1, 16'd0, 16'd0, 8'd0);
    clear_logs(); do_start(); wait_done(1'b0, 2000); verify(1);

    // Abort in the anodic phase of pulse 0.
    set_cfg(5'd5, 5'd6, 1'b0, 16'd2, 16'd1, 8'd7);
    clear_logs(); do_start();
    wait_cmds(2);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(1'b0, 2000);
    check("abort_cmd_count", cmds.size(), 3);
    if (cmds.size() == 3) check("abort_off_phase", cmds[2].ph, 2'b00);
    check("abort_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("abort_flag", {31'd0, done_ab[0]}, 32'd1);

    // Abort withdraws a pending cathodic command.
    rdy_mode = 2;
    set_cfg(5'd1, 5'd2, 1'b0, 16'd1, 16'd1, 8'd3);
    clear_logs(); do_start();
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(1'b0, 2000);
    check("withdraw_cmd_count", cmds.size(), 1);
    if (cmds.size() == 1) check("withdraw_phase", cmds[0].ph, 2'b00);
    if (done_ab.size() == 1) check("withdraw_abort_flag", {31'd0, done_ab[0]}, 32'd1);

    // Reset asserted during the gap.
    rdy_mode = 0;
    set_cfg(5'd10, 5'd11, 1'b0, 16'd1, 16'd5, 8'd3);
    clear_logs(); do_start();
    wait_cmds(3);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset_in_gap");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("reset_no_cmd", cmds.size(), 3);
    check("reset_no_done", done_cyc.size(), 0);
    check_outputs_zero("idle_after_midtrain_reset");
    clear_logs(); do_start(); wait_done(1'b0, 2000); verify(1);

    // Start pulses and cfg changes while busy.
    rdy_mode = 1;
    set_cfg(5'd20, 5'd7, 1'b1, 16'd2, 16'd1, 8'd2);
    clear_logs(); do_start(); wait_done(1'b1, 2000); verify(0);

    for (int t = 0; t < 12; t++) begin
      mode = $urandom_range(0, 2);
      rdy_mode = mode;
      set_cfg(5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom_range(0, 3)),
              16'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
      clear_logs(); do_start(); wait_done(1'b1, 3000);
      verify((mode == 0) ? 1 : (mode == 2) ? 6 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
